sim_phase_controller: RTL and testbench
=======================================

Name: sim_phase_controller

Overview:
- Testbench-support sequencer that runs off the generated simulation clock and sequences a DUT run (e.g. a PIFO block) through fixed phases: reset, warm-up, stimulus, drain and verdict.
- Owns the DUT reset and the stimulus/checker enables, counts cycles per phase, and flags drain timeouts or aborts.
- Written fully synchronous so it can also be used in FPGA test harnesses.

Parameters:
- RESET_CYCLES, 10, cycles dut_rst is held after start (>=1)
- WARMUP_CYCLES, 5, idle cycles between reset release and stimulus (>=1)
- RUN_CYCLES, 1000, cycles stim_en is asserted (>=1)
- DRAIN_TIMEOUT, 200, max cycles to wait for dut_idle after stimulus (>=1)
- CNT_W, 32, width of phase and total cycle counters (must hold max parameter value)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a run; sampled in IDLE, DONE, FAIL only
- abort  input  1  force run to FAIL; effective in RESET..DRAIN
- dut_idle  input  1  DUT reports no work outstanding
- dut_rst  output  1  reset to DUT, active-high
- stim_en  output  1  stimulus generator enable
- chk_en  output  1  scoreboard/checker enable
- phase  output  3  current state encoding
- status  output  2  0 none, 1 pass, 2 timeout, 3 abort
- done  output  1  run finished (pass or fail)
- phase_cnt  output  CNT_W  cycles elapsed in current phase
- total_cnt  output  CNT_W  cycles since leaving IDLE, saturating at all-ones

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst). All outputs are registered, with no combinational input-to-output path.
- Reset values: phase=IDLE, dut_rst=1, stim_en=0, chk_en=0, status=0, done=0, phase_cnt=0, total_cnt=0. rst mid-run aborts silently to these values; status is not set to abort.
- States:
  - IDLE=0: dut_rst=1. Waits for start.
  - RESET=1: dut_rst=1.
  - WARMUP=2: dut_rst=0, chk_en=1.
  - RUN=3: stim_en=1, chk_en=1.
  - DRAIN=4: stim_en=0, chk_en=1.
  - DONE=5: done=1, status=1.
  - FAIL=6: done=1, status=2 or 3.
  - Encoding 7 is illegal and recovers to IDLE on the next cycle.
- Phase counter: phase_cnt clears to 0 on every state entry and increments each cycle in the state.
- Transitions:
  - IDLE -> RESET when start=1.
  - RESET -> WARMUP when phase_cnt==RESET_CYCLES-1, so dut_rst is high for exactly RESET_CYCLES cycles in RESET.
  - WARMUP -> RUN when phase_cnt==WARMUP_CYCLES-1.
  - RUN -> DRAIN when phase_cnt==RUN_CYCLES-1, so stim_en is high for exactly RUN_CYCLES consecutive cycles.
  - DRAIN -> DONE when dut_idle=1.
  - DRAIN -> FAIL(status=2) when phase_cnt==DRAIN_TIMEOUT-1 with dut_idle=0.
  - dut_idle=1 on the final timeout cycle yields DONE (idle wins).
  - dut_idle is sampled in DRAIN only. Its first sample is the cycle after the last stim_en cycle.
- Abort: abort=1 in RESET, WARMUP, RUN or DRAIN -> FAIL(status=3) next cycle. Abort has priority over every other transition, including dut_idle. abort is ignored in IDLE, DONE and FAIL.
- Entry into DONE or FAIL: dut_rst=0, stim_en=0, chk_en=0. status and done hold until start or rst.
- Restart: start=1 in DONE or FAIL -> RESET next cycle. On that transition status, done, phase_cnt and total_cnt clear. start in other states is ignored.
- total_cnt:
  - 0 in IDLE.
  - Increments every cycle in RESET through DRAIN.
  - Freezes in DONE or FAIL.
  - Saturates at all-ones with no wrap.
- Output timing: outputs reflect the current state, registered together with it. A state change at edge k is visible on all outputs immediately after edge k.

Test Plan (RESET=4, WARMUP=2, RUN=8, DRAIN_TIMEOUT=5):
- Normal run: start pulse at cycle 0, dut_idle=1 -> RESET cycles 1-4, WARMUP 5-6, stim_en high 7-14 (8 cycles), DRAIN 15, DONE at 16; status=1, total_cnt=15.
- Drain timeout: dut_idle=0 throughout -> DRAIN cycles 15-19, FAIL at 20; status=2, done=1, stim_en=0.
- Idle on last cycle: dut_idle rises only at cycle 19 -> DONE at 20; status=1, not a timeout.
- Abort mid-RUN: abort at cycle 10 -> FAIL at 11; status=3, stim_en low from 11. Abort in IDLE and in DONE has no effect.
- Restart and start filtering: start in DONE -> RESET next cycle with status=0, total_cnt=0. start during RUN is ignored and the run length stays at 8.
- Mid-run reset: rst during WARMUP -> next cycle phase=0, dut_rst=1, all counters 0, status=0.

Source files
------------

// File: rtl/sim_phase_controller.sv
// Run sequencer for a simulation or FPGA harness: drives the DUT reset and the
// stimulus/checker enables through reset, warm-up, run, drain and verdict phases.
module sim_phase_controller #(
   parameter int RESET_CYCLES  = 10,
   parameter int WARMUP_CYCLES = 5,
   parameter int RUN_CYCLES    = 1000,
   parameter int DRAIN_TIMEOUT = 200,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_idle,
   output logic             dut_rst,
   output logic             stim_en,
   output logic             chk_en,
   output logic [2:0]       phase,
   output logic [1:0]       status,
   output logic             done,
   output logic [CNT_W-1:0] phase_cnt,
   output logic [CNT_W-1:0] total_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RESET  = 3'd1;
   localparam logic [2:0] S_WARMUP = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_FAIL   = 3'd6;

   localparam logic [1:0] ST_NONE    = 2'd0;
   localparam logic [1:0] ST_PASS    = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_ABORT   = 2'd3;

   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

   logic [2:0]       next_phase;
   logic [1:0]       next_status;
   logic [CNT_W-1:0] next_phase_cnt;
   logic [CNT_W-1:0] next_total_cnt;
   logic [CNT_W-1:0] phase_cnt_inc;
   logic [CNT_W-1:0] total_cnt_inc;
   logic             entering;

   assign phase_cnt_inc = (&phase_cnt) ? phase_cnt : phase_cnt + 1'b1;
   assign total_cnt_inc = (&total_cnt) ? total_cnt : total_cnt + 1'b1;

   // Abort is checked first in every active phase so it beats all other exits.
   always_comb begin
      next_phase = phase;
      case (phase)
         S_IDLE: begin
            if (start) next_phase = S_RESET;
         end
         S_RESET: begin
            if (abort)                        next_phase = S_FAIL;
            else if (phase_cnt == RESET_LAST) next_phase = S_WARMUP;
         end
         S_WARMUP: begin
            if (abort)                         next_phase = S_FAIL;
            else if (phase_cnt == WARMUP_LAST) next_phase = S_RUN;
         end
         S_RUN: begin
            if (abort)                      next_phase = S_FAIL;
            else if (phase_cnt == RUN_LAST) next_phase = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                        next_phase = S_FAIL;
            else if (dut_idle)                next_phase = S_DONE;
            else if (phase_cnt == DRAIN_LAST) next_phase = S_FAIL;
         end
         S_DONE, S_FAIL: begin
            if (start) next_phase = S_RESET;
         end
         default: next_phase = S_IDLE;
      endcase
   end

   assign entering = (next_phase != phase);

   // Verdict code is latched on entry to FAIL and then held until a restart.
   always_comb begin
      next_status = ST_NONE;
      case (next_phase)
         S_DONE: next_status = ST_PASS;
         S_FAIL: begin
            if (phase == S_FAIL) next_status = status;
            else if (abort)      next_status = ST_ABORT;
            else                 next_status = ST_TIMEOUT;
         end
         default: next_status = ST_NONE;
      endcase
   end

   // total_cnt starts at 0 on the first RESET cycle and stops advancing once
   // the verdict state has been entered.
   always_comb begin
      next_phase_cnt = entering ? '0 : phase_cnt_inc;
      next_total_cnt = total_cnt;
      case (next_phase)
         S_IDLE:                     next_total_cnt = '0;
         S_RESET:                    next_total_cnt = entering ? '0 : total_cnt_inc;
         S_WARMUP, S_RUN, S_DRAIN:   next_total_cnt = total_cnt_inc;
         S_DONE, S_FAIL:             next_total_cnt = entering ? total_cnt_inc : total_cnt;
         default:                    next_total_cnt = '0;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge
   // as the phase itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= S_IDLE;
         dut_rst   <= 1'b1;
         stim_en   <= 1'b0;
         chk_en    <= 1'b0;
         status    <= ST_NONE;
         done      <= 1'b0;
         phase_cnt <= '0;
         total_cnt <= '0;
      end else begin
         phase     <= next_phase;
         dut_rst   <= (next_phase == S_IDLE) || (next_phase == S_RESET);
         stim_en   <= (next_phase == S_RUN);
         chk_en    <= (next_phase == S_WARMUP) || (next_phase == S_RUN) || (next_phase == S_DRAIN);
         status    <= next_status;
         done      <= (next_phase == S_DONE) || (next_phase == S_FAIL);
         phase_cnt <= next_phase_cnt;
         total_cnt <= next_total_cnt;
      end
   end

endmodule

// File: tb/tb_sim_phase_controller.sv
// Table-driven bench for sim_phase_controller: every row is one clock of inputs
// plus the state expected right after that clock edge.
module tb_sim_phase_controller;

   localparam int RST_C = 4;
   localparam int WRM_C = 2;
   localparam int RUN_C = 8;
   localparam int DRN_C = 5;
   localparam int CW    = 32;

   localparam logic [2:0] P_IDLE   = 3'd0;
   localparam logic [2:0] P_RESET  = 3'd1;
   localparam logic [2:0] P_WARMUP = 3'd2;
   localparam logic [2:0] P_RUN    = 3'd3;
   localparam logic [2:0] P_DRAIN  = 3'd4;
   localparam logic [2:0] P_DONE   = 3'd5;
   localparam logic [2:0] P_FAIL   = 3'd6;

   typedef struct {
      logic        rst;
      logic        start;
      logic        abort;
      logic        idle;
      logic [2:0]  ph;
      logic [1:0]  st;
      logic [31:0] pc;
      logic [31:0] tc;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic          dut_idle;
   logic          dut_rst;
   logic          stim_en;
   logic          chk_en;
   logic [2:0]    phase;
   logic [1:0]    status;
   logic          done;
   logic [CW-1:0] phase_cnt;
   logic [CW-1:0] total_cnt;

   int   total;
   int   bad;
   vec_t tbl[$];
   vec_t sbq[$];

   sim_phase_controller #(
      .RESET_CYCLES (RST_C),
      .WARMUP_CYCLES(WRM_C),
      .RUN_CYCLES   (RUN_C),
      .DRAIN_TIMEOUT(DRN_C),
      .CNT_W        (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .dut_idle (dut_idle),
      .dut_rst  (dut_rst),
      .stim_en  (stim_en),
      .chk_en   (chk_en),
      .phase    (phase),
      .status   (status),
      .done     (done),
      .phase_cnt(phase_cnt),
      .total_cnt(total_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus loop never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic r, input logic s, input logic a, input logic i,
                               input logic [2:0] ph, input int pc, input int tc, input logic [1:0] st);
      vec_t v;
      v.rst = r; v.start = s; v.abort = a; v.idle = i;
      v.ph = ph; v.pc = 32'(pc); v.tc = 32'(tc); v.st = st;
      return v;
   endfunction

   // One run starting with a start pulse; row c holds the state of cycle c,
   // whose inputs are driven in cycle c-1.
   // kind 0: idle all along, DONE at 16; 1: never idle, FAIL(2) at 20;
   // 2: idle only at cycle 19, DONE at 20; 3: abort from cycle 10, FAIL(3) at 11;
   // 4: stop after five cycles (for the reset-in-WARMUP case).
   task automatic addRun(input int kind);
      int   n;
      int   fin;
      vec_t v;
      case (kind)
         0: begin n = 17; fin = 16; end
         1: begin n = 21; fin = 20; end
         2: begin n = 21; fin = 20; end
         3: begin n = 12; fin = 11; end
         default: begin n = 5; fin = 16; end
      endcase
      for (int c = 1; c <= n; c++) begin
         v.rst   = 1'b0;
         v.start = (c == 1) || (c == 11 && kind != 3);
         v.abort = (kind == 3) && (c >= 11);
         v.idle  = (kind == 0) || (kind == 2 && c == 20);
         v.st    = 2'd0;
         if (c <= 4)        begin v.ph = P_RESET;  v.pc = 32'(c - 1);  end
         else if (c <= 6)   begin v.ph = P_WARMUP; v.pc = 32'(c - 5);  end
         else if (c >= fin) begin
            v.ph = (kind == 1 || kind == 3) ? P_FAIL : P_DONE;
            v.pc = 32'(c - fin);
            v.st = (kind == 1) ? 2'd2 : (kind == 3) ? 2'd3 : 2'd1;
         end
         else if (c <= 14)  begin v.ph = P_RUN;    v.pc = 32'(c - 7);  end
         else               begin v.ph = P_DRAIN;  v.pc = 32'(c - 15); end
         v.tc = 32'((c - 1 < fin - 1) ? c - 1 : fin - 1);
         tbl.push_back(v);
      end
   endtask

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst      = v.rst;
      start    = v.start;
      abort    = v.abort;
      dut_idle = v.idle;
      sbq.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t  e;
      string t;
      if (sbq.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL row%0d.queue: actual=empty required=entry", idx);
         return;
      end
      e = sbq.pop_front();
      t = $sformatf("row%0d", idx);
      checkField({t, ".phase"},     32'(phase),     32'(e.ph));
      checkField({t, ".status"},    32'(status),    32'(e.st));
      checkField({t, ".phase_cnt"}, phase_cnt,      e.pc);
      checkField({t, ".total_cnt"}, total_cnt,      e.tc);
      checkField({t, ".dut_rst"},   32'(dut_rst),   32'(e.ph == P_IDLE || e.ph == P_RESET));
      checkField({t, ".stim_en"},   32'(stim_en),   32'(e.ph == P_RUN));
      checkField({t, ".chk_en"},    32'(chk_en),    32'(e.ph == P_WARMUP || e.ph == P_RUN || e.ph == P_DRAIN));
      checkField({t, ".done"},      32'(done),      32'(e.ph == P_DONE || e.ph == P_FAIL));
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      dut_idle = 1'b0;

      // Reset values, then abort in IDLE (ignored).
      tbl.push_back(mk(1, 0, 0, 0, P_IDLE, 0, 0, 2'd0));
      tbl.push_back(mk(1, 0, 0, 0, P_IDLE, 0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 1, 0, P_IDLE, 1, 0, 2'd0));
      // Normal run with a stray start in RUN, then abort in DONE (ignored).
      addRun(0);
      tbl.push_back(mk(0, 0, 1, 1, P_DONE, 2, 15, 2'd1));
      // Restart from DONE: idle on last drain cycle, then timeout, then abort.
      addRun(2);
      addRun(1);
      addRun(3);
      // Restart from FAIL, reset asserted in WARMUP.
      addRun(4);
      tbl.push_back(mk(1, 0, 0, 0, P_IDLE, 0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 0, 0, P_IDLE, 1, 0, 2'd0));

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         @(posedge clk);
         #1;
         checkOutput(i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
